// File: rtl/sqrt_check.sv
// sqrt_check: sequential square-root result checker.
// Squares the 4-bit root with a shift-and-add loop (one partial product per
// cycle) and confirms root^2 <= N < (root+1)^2.
//
// Ports:
//   clk      system clock
//   rstN     asynchronous active-low reset
//   St       one-cycle start pulse; accepted only in IDLE or DONE
//   N        8-bit operand the root was computed from (sampled on start)
//   sqrt     4-bit root under test (sampled on start)
//   done     check complete; held until the next accepted start
//   pass     1 = root is correct (valid when done)
//   square   sqrt^2 (valid when done)
//   err_cnt  saturating count of failed checks
//
// Optional feature macro: SQRT_CHECK_ERRCNT_EN
//   defined   -> err_cnt counts failed checks, saturating at 8'hFF
//   undefined -> err_cnt is tied to 8'h00
module sqrt_check (
  input  logic       clk,
  input  logic       rstN,
  input  logic       St,
  input  logic [7:0] N,
  input  logic [3:0] sqrt,
  output logic       done,
  output logic       pass,
  output logic [7:0] square,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, MUL, CHK, DONE} state_t;

  state_t     state, state_nx;
  logic [7:0] n_r;
  logic [3:0] s_r;
  logic [7:0] acc;
  logic [1:0] cnt;

  logic       start;
  logic [7:0] addend;
  logic [8:0] hi;
  logic       pass_c;

  // St is only honoured when no check is in flight.
  assign start  = St && (state == IDLE || state == DONE);
  assign addend = {4'b0, s_r} << cnt;
  // (root+1)^2 = root^2 + 2*root + 1; needs 9 bits for root = 15.
  assign hi     = {1'b0, acc} + {4'b0, s_r, 1'b0} + 9'd1;
  assign pass_c = (acc <= n_r) && ({1'b0, n_r} < hi);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (St) state_nx = MUL;
      MUL:        if (cnt == 2'd3) state_nx = CHK;
      CHK:        state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      n_r    <= '0;
      s_r    <= '0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      pass   <= 1'b0;
      square <= '0;
    end else if (start) begin
      n_r  <= N;
      s_r  <= sqrt;
      acc  <= '0;
      cnt  <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else begin
      case (state)
        MUL: begin
          if (s_r[cnt]) acc <= acc + addend;
          cnt <= cnt + 2'd1;
        end
        CHK: begin
          square <= acc;
          pass   <= pass_c;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SQRT_CHECK_ERRCNT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)
      err_cnt <= '0;
    else if (state == CHK && !pass_c && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sqrt_check.sv
// Directed testbench for sqrt_check. Expected squares and pass flags are
// hand-computed constants in each call; err_cnt expectation follows the
// build macro.
module tb_sqrt_check;

  logic       clk;
  logic       rstN;
  logic       St;
  logic [7:0] N;
  logic [3:0] sqrt;
  logic       done;
  logic       pass;
  logic [7:0] square;
  logic [7:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_err = 8'h00;

  sqrt_check dut (
    .clk     (clk),
    .rstN    (rstN),
    .St      (St),
    .N       (N),
    .sqrt    (sqrt),
    .done    (done),
    .pass    (pass),
    .square  (square),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full check: pulse St at E0, optionally a busy pulse at E2 with other
  // operands, operands scrambled after E0, results checked after E5.
  task automatic run(input string tag, input logic [7:0] n, input logic [3:0] s,
                     input logic [7:0] esq, input logic ep, input bit busy, input bit full);
    @(negedge clk);
    St = 1'b1; N = n; sqrt = s;
    @(posedge clk);                      // E0
    @(negedge clk);
    St = 1'b0; N = ~n; sqrt = ~s;
    if (full) chk({tag, "_done_lo_e0"}, done, 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);                    // E1..E4
      @(negedge clk);
      if (busy && i == 1) begin St = 1'b1; N = 8'h10; sqrt = 4'd4; end
      if (i == 2) St = 1'b0;
    end
    if (full) chk({tag, "_done_lo_e4"}, done, 0);
    @(posedge clk);                      // E5
`ifdef SQRT_CHECK_ERRCNT_EN
    if (!ep && exp_err != 8'hFF) exp_err = exp_err + 8'd1;
`endif
    @(negedge clk);
    if (full) begin
      chk({tag, "_done"},   done,   1);
      chk({tag, "_square"}, square, esq);
      chk({tag, "_pass"},   pass,   ep);
      chk({tag, "_errcnt"}, err_cnt, exp_err);
    end
  endtask

  initial begin
    rstN = 1'b0; St = 1'b0; N = '0; sqrt = '0;
    repeat (2) @(negedge clk);
    chk("rst_done",   done,    0);
    chk("rst_pass",   pass,    0);
    chk("rst_square", square,  0);
    chk("rst_errcnt", err_cnt, 0);
    rstN = 1'b1;

    run("p81",   8'h51, 4'd9,  8'h51, 1'b1, 0, 1);
    // DONE holds outputs
    repeat (3) @(negedge clk);
    chk("hold_done",   done,   1);
    chk("hold_square", square, 8'h51);
    run("f80",   8'h50, 4'd9,  8'h51, 1'b0, 0, 1);
    run("max",   8'hFF, 4'hF,  8'hE1, 1'b1, 0, 1);
    run("zero",  8'h00, 4'd0,  8'h00, 1'b1, 0, 1);
    run("z1",    8'h00, 4'd1,  8'h01, 1'b0, 0, 1);
    run("busy",  8'h51, 4'd9,  8'h51, 1'b1, 1, 1);
    run("r10",   8'h6F, 4'd10, 8'h64, 1'b1, 0, 1);
    run("r10hi", 8'h79, 4'd10, 8'h64, 1'b0, 0, 1);

    // reset mid-MUL
    @(negedge clk);
    St = 1'b1; N = 8'h51; sqrt = 4'd9;
    @(posedge clk);
    @(negedge clk); St = 1'b0;
    @(posedge clk); @(posedge clk);      // E1, E2
    @(negedge clk);
    rstN = 1'b0;
    #1;
    exp_err = 8'h00;
    chk("mrst_done",   done,    0);
    chk("mrst_pass",   pass,    0);
    chk("mrst_square", square,  0);
    chk("mrst_errcnt", err_cnt, 0);
    @(negedge clk);
    rstN = 1'b1;
    run("post_rst", 8'hC4, 4'd14, 8'hC4, 1'b1, 0, 1);

    // saturation: 260 failing checks
    for (int k = 0; k < 260; k++) run("sat", 8'h00, 4'd1, 8'h01, 1'b0, 0, (k == 259));
`ifdef SQRT_CHECK_ERRCNT_EN
    chk("sat_const", {24'b0, exp_err}, 32'hFF);
`endif
    run("sat_after", 8'h00, 4'd2, 8'h04, 1'b0, 0, 1);
    run("sat_pass",  8'h05, 4'd2, 8'h04, 1'b1, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
